// File: rtl/sd_cmd_queue_pkg.sv
// sd_cmd_queue_pkg: shared types and constants for the SD command issue queue.
//   - state_e     : one-hot issue FSM encoding
//   - CODE_*      : done_code values reported with each result
//   - ENTRY_W/OFS_*: queue entry layout {arg[31:0], cmd_set[15:0], rd, wr}
package sd_cmd_queue_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LAUNCH = 4'b0010,
    ST_BUSY   = 4'b0100,
    ST_REPORT = 4'b1000
  } state_e;

  localparam logic [1:0] CODE_OK         = 2'd0;
  localparam logic [1:0] CODE_MASTER_ERR = 2'd1;
  localparam logic [1:0] CODE_LAUNCH_TO  = 2'd2;

  localparam int unsigned ENTRY_W     = 50;
  localparam int unsigned OFS_WR      = 0;
  localparam int unsigned OFS_RD      = 1;
  localparam int unsigned OFS_CMD_SET = 2;
  localparam int unsigned OFS_ARG     = 18;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] arg,
                                                    input logic [15:0] cmd_set,
                                                    input logic        rd,
                                                    input logic        wr);
    return {arg, cmd_set, rd, wr};
  endfunction

endpackage

// File: rtl/sd_cmd_fifo.sv
// sd_cmd_fifo: synchronous FIFO of DEPTH entries (power of two) holding
// queued command requests. Pointers carry a wrap bit for full/empty.
//   clk, rst_n      : clock, synchronous active-low reset
//   push, wdata     : write at tail (ignored when full)
//   pop             : drop head (ignored when empty)
//   rdata           : head entry
//   full, empty     : status
//   level           : occupancy 0..DEPTH
module sd_cmd_fifo
  import sd_cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               push_ok, pop_ok;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level    = wr_ptr_q - rd_ptr_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sd_cmd_issue_queue.sv
// sd_cmd_issue_queue: buffers SD command requests and issues them one at a
// time to the SD command master, reporting one result per command.
//   CLK_PAD_IO, RST_PAD_I          : clock, synchronous active-low reset
//   req_*                          : request push interface (req_ready = !full)
//   New_CMD, ARG_REG, CMD_SET_REG,
//   data_read, data_write          : head entry / launch strobe to the master
//   STATUS_REG, ERR_INT_REG,
//   RESP_1_REG                     : master status, error and response inputs
//   done_*                         : result record (done_valid is a pulse)
//   q_level                        : queue occupancy
// Optional: define SD_CMD_QUEUE_RETRY_EN to relaunch commands that end with a
// CRC error, up to MAX_RETRY times.
module sd_cmd_issue_queue
  import sd_cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LAUNCH_TO = 16,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                   CLK_PAD_IO,
  input  logic                   RST_PAD_I,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_arg,
  input  logic [15:0]            req_cmd_set,
  input  logic                   req_rd,
  input  logic                   req_wr,
  output logic                   New_CMD,
  output logic [31:0]            ARG_REG,
  output logic [15:0]            CMD_SET_REG,
  output logic                   data_read,
  output logic                   data_write,
  input  logic [15:0]            STATUS_REG,
  input  logic [15:0]            ERR_INT_REG,
  input  logic [31:0]            RESP_1_REG,
  output logic                   done_valid,
  output logic                   done_err,
  output logic [1:0]             done_code,
  output logic [15:0]            done_errs,
  output logic [31:0]            done_resp,
  output logic [$clog2(DEPTH):0] q_level
);

  localparam int unsigned LCW = $clog2(LAUNCH_TO + 1);

  state_e             state_q, state_d;
  logic [LCW-1:0]     lcnt_q, lcnt_d;
  logic               tmo_q, tmo_d;
  logic               res_err_q, res_err_d;
  logic [1:0]         res_code_q, res_code_d;
  logic [15:0]        res_errs_q, res_errs_d;
  logic [31:0]        res_resp_q, res_resp_d;

  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty, pop, report;
  logic               master_err, live_err;
  logic [1:0]         live_code;

`ifdef SD_CMD_QUEUE_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;
  logic          unused_bits;
  assign unused_bits = ^{STATUS_REG[15:1], ERR_INT_REG[15:4], ERR_INT_REG[2]};
`else
  logic          unused_bits;
  assign unused_bits = ^{STATUS_REG[15:1], ERR_INT_REG[15:4], ERR_INT_REG[2], 32'(MAX_RETRY)};
`endif

  sd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK_PAD_IO),
    .rst_n (RST_PAD_I),
    .push  (req_valid),
    .wdata (pack_entry(req_arg, req_cmd_set, req_rd, req_wr)),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (q_level)
  );

  always_comb begin
    state_d    = state_q;
    lcnt_d     = lcnt_q;
    tmo_d      = tmo_q;
    res_err_d  = res_err_q;
    res_code_d = res_code_q;
    res_errs_d = res_errs_q;
    res_resp_d = res_resp_q;
    pop        = 1'b0;
    report     = 1'b0;
`ifdef SD_CMD_QUEUE_RETRY_EN
    retry_d    = retry_q;
`endif

    master_err = ERR_INT_REG[3] | ERR_INT_REG[1] | ERR_INT_REG[0];
    live_err   = tmo_q | master_err;
    live_code  = tmo_q ? CODE_LAUNCH_TO : (master_err ? CODE_MASTER_ERR : CODE_OK);

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          lcnt_d  = '0;
          tmo_d   = 1'b0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // lcnt_q counts completed LAUNCH cycles, so New_CMD stays high for
        // exactly LAUNCH_TO cycles on an abandoned launch.
        if (STATUS_REG[0]) begin
          state_d = ST_BUSY;
        end else if (lcnt_q == LCW'(LAUNCH_TO - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_REPORT;
        end else begin
          lcnt_d  = lcnt_q + LCW'(1);
        end
      end
      ST_BUSY: begin
        if (!STATUS_REG[0]) state_d = ST_REPORT;
      end
      ST_REPORT: begin
`ifdef SD_CMD_QUEUE_RETRY_EN
        if (ERR_INT_REG[1] && (retry_q < RW'(MAX_RETRY))) begin
          retry_d = retry_q + RW'(1);
          lcnt_d  = '0;
          tmo_d   = 1'b0;
          state_d = ST_LAUNCH;
        end else begin
          report  = 1'b1;
          pop     = 1'b1;
          retry_d = '0;
          tmo_d   = 1'b0;
          state_d = ST_IDLE;
        end
`else
        report  = 1'b1;
        pop     = 1'b1;
        tmo_d   = 1'b0;
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (report) begin
      res_err_d  = live_err;
      res_code_d = live_code;
      res_errs_d = ERR_INT_REG;
      res_resp_d = RESP_1_REG;
    end
  end

  always_ff @(posedge CLK_PAD_IO) begin
    if (!RST_PAD_I) begin
      state_q    <= ST_IDLE;
      lcnt_q     <= '0;
      tmo_q      <= 1'b0;
      res_err_q  <= 1'b0;
      res_code_q <= CODE_OK;
      res_errs_q <= '0;
      res_resp_q <= '0;
`ifdef SD_CMD_QUEUE_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lcnt_q     <= lcnt_d;
      tmo_q      <= tmo_d;
      res_err_q  <= res_err_d;
      res_code_q <= res_code_d;
      res_errs_q <= res_errs_d;
      res_resp_q <= res_resp_d;
`ifdef SD_CMD_QUEUE_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  // Result fields show the live capture during the reporting cycle so they
  // line up with done_valid, then hold the registered copy.
  assign req_ready   = !fifo_full;
  assign New_CMD     = (state_q == ST_LAUNCH);
  assign ARG_REG     = fifo_empty ? '0   : head[OFS_ARG +: 32];
  assign CMD_SET_REG = fifo_empty ? '0   : head[OFS_CMD_SET +: 16];
  assign data_read   = fifo_empty ? 1'b0 : head[OFS_RD];
  assign data_write  = fifo_empty ? 1'b0 : head[OFS_WR];
  assign done_valid  = report;
  assign done_err    = report ? live_err    : res_err_q;
  assign done_code   = report ? live_code   : res_code_q;
  assign done_errs   = report ? ERR_INT_REG : res_errs_q;
  assign done_resp   = report ? RESP_1_REG  : res_resp_q;

endmodule

// File: tb/tb_sd_cmd_issue_queue.sv
// Directed testbench for sd_cmd_issue_queue with a small behavioural SD
// command master (setup cycle, then STATUS_REG[0] busy for m_busy cycles).
module tb_sd_cmd_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rd, req_wr;
  logic [31:0] req_arg;
  logic [15:0] req_cmd_set;
  logic        New_CMD, data_read, data_write;
  logic [31:0] ARG_REG;
  logic [15:0] CMD_SET_REG;
  logic [15:0] STATUS_REG, ERR_INT_REG;
  logic [31:0] RESP_1_REG;
  logic        done_valid, done_err;
  logic [1:0]  done_code;
  logic [15:0] done_errs;
  logic [31:0] done_resp;
  logic [2:0]  q_level;

  always #5 clk = ~clk;

  sd_cmd_issue_queue #(.DEPTH(4), .LAUNCH_TO(16), .MAX_RETRY(2)) dut (
    .CLK_PAD_IO (clk),        .RST_PAD_I  (rst_n),
    .req_valid  (req_valid),  .req_ready  (req_ready),
    .req_arg    (req_arg),    .req_cmd_set(req_cmd_set),
    .req_rd     (req_rd),     .req_wr     (req_wr),
    .New_CMD    (New_CMD),    .ARG_REG    (ARG_REG),
    .CMD_SET_REG(CMD_SET_REG),.data_read  (data_read),
    .data_write (data_write), .STATUS_REG (STATUS_REG),
    .ERR_INT_REG(ERR_INT_REG),.RESP_1_REG (RESP_1_REG),
    .done_valid (done_valid), .done_err   (done_err),
    .done_code  (done_code),  .done_errs  (done_errs),
    .done_resp  (done_resp),  .q_level    (q_level)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural master
  int          m_st = 0, m_cnt = 0, m_att = 0, m_busy = 20;
  logic        m_stall = 1'b0;
  logic [15:0] m_err_first = '0, m_err_rest = '0;
  logic [31:0] m_resp = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_st = 0; STATUS_REG = '0; ERR_INT_REG = '0; RESP_1_REG = '0;
    end else begin
      case (m_st)
        0: if (New_CMD && !m_stall) m_st = 1;
        1: begin STATUS_REG = 16'h0001; ERR_INT_REG = '0; m_cnt = m_busy; m_st = 2; end
        default: begin
          m_cnt--;
          if (m_cnt == 0) begin
            STATUS_REG  = '0;
            ERR_INT_REG = (m_att == 0) ? m_err_first : m_err_rest;
            RESP_1_REG  = m_resp;
            m_att++;
            m_st = 0;
          end
        end
      endcase
    end
  end

  // Monitor
  logic [31:0] got_arg[$];
  logic [31:0] got_resp[$];
  logic [15:0] got_errs[$];
  logic [1:0]  got_code[$];
  logic        got_err[$];
  logic        got_ncmd[$];
  logic [2:0]  got_lvl[$];
  logic        got_rdy[$];
  int          n_launch = 0, ncmd_hi = 0;
  logic        ncmd_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (New_CMD) ncmd_hi++;
    if (New_CMD && !ncmd_prev) n_launch++;
    ncmd_prev = New_CMD;
    if (done_valid) begin
      got_arg.push_back(ARG_REG);   got_resp.push_back(done_resp);
      got_errs.push_back(done_errs); got_code.push_back(done_code);
      got_err.push_back(done_err);  got_ncmd.push_back(New_CMD);
      got_lvl.push_back(q_level);   got_rdy.push_back(req_ready);
    end
  end

  task automatic clear_mon();
    got_arg.delete(); got_resp.delete(); got_errs.delete(); got_code.delete();
    got_err.delete(); got_ncmd.delete(); got_lvl.delete(); got_rdy.delete();
    n_launch = 0; ncmd_hi = 0; m_att = 0;
  endtask

  task automatic push(input logic [31:0] a, input logic [15:0] cs, input logic rd, input logic wr);
    req_valid = 1'b1; req_arg = a; req_cmd_set = cs; req_rd = rd; req_wr = wr;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && got_arg.size() < n; i++) @(negedge clk);
    check_val({tag, "_ndone"}, 64'(got_arg.size()), 64'(n));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_arg = '0; req_cmd_set = '0; req_rd = 1'b0; req_wr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_level",  q_level, 0);
    check_val("rst_ready",  req_ready, 1);
    check_val("rst_newcmd", New_CMD, 0);
    check_val("rst_dvalid", done_valid, 0);
    check_val("rst_arg",    ARG_REG, 0);
    check_val("rst_resp",   done_resp, 0);

    // Single command
    clear_mon(); m_busy = 20; m_resp = 32'h1234_5678; m_err_first = '0; m_err_rest = '0;
    push(32'h0000_01AA, 16'h0819, 1'b1, 1'b0);
    check_val("single_lat1_newcmd", New_CMD, 0);
    check_val("single_lat1_level",  q_level, 1);
    @(negedge clk);
    check_val("single_lat2_newcmd", New_CMD, 1);
    check_val("single_arg_out",     ARG_REG, 32'h0000_01AA);
    check_val("single_cmdset_out",  CMD_SET_REG, 16'h0819);
    check_val("single_rd_out",      data_read, 1);
    check_val("single_wr_out",      data_write, 0);
    wait_done("single", 1, 100);
    check_val("single_err",  got_err[0], 0);
    check_val("single_code", got_code[0], 0);
    check_val("single_resp", got_resp[0], 32'h1234_5678);
    check_val("single_dwell", 64'(ncmd_hi), 2);
    repeat (2) @(negedge clk);
    check_val("single_level_end", q_level, 0);
    check_val("single_resp_hold", done_resp, 32'h1234_5678);

    // Fill: long busy so the queue backs up
    clear_mon(); m_busy = 40; m_resp = 32'hA5A5_0000;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(i), 16'h0100, 1'b0, 1'b1);
    check_val("fill_level4", q_level, 4);
    check_val("fill_ready0", req_ready, 0);
    req_valid = 1'b1; req_arg = 32'hDEAD; req_cmd_set = 16'h0;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    check_val("fill_5th_ignored", q_level, 4);
    wait_done("fill", 4, 600);
    for (int i = 0; i < 4; i++) check_val($sformatf("fill_order%0d", i), got_arg[i], 32'h100 + 32'(i));
    check_val("fill_report_lvl", got_lvl[0], 4);
    check_val("fill_report_rdy", got_rdy[0], 0);
    repeat (60) @(negedge clk);
    check_val("fill_no_extra", 64'(got_arg.size()), 4);
    check_val("fill_level_end", q_level, 0);

    // Launch timeout
    clear_mon(); m_stall = 1'b1;
    push(32'h0000_0777, 16'h0D00, 1'b0, 1'b0);
    wait_done("tmo", 1, 100);
    check_val("tmo_newcmd_cycles", 64'(ncmd_hi), 16);
    check_val("tmo_code",   got_code[0], 2);
    check_val("tmo_err",    got_err[0], 1);
    check_val("tmo_ncmd_at_report", got_ncmd[0], 0);
    repeat (2) @(negedge clk);
    check_val("tmo_popped", q_level, 0);
    m_stall = 1'b0;

    // CRC error on every attempt
    clear_mon(); m_busy = 5; m_err_first = 16'h0002; m_err_rest = 16'h0002; m_resp = 32'h0000_0C0C;
    push(32'h0000_0CCC, 16'h1119, 1'b0, 1'b0);
    wait_done("crc", 1, 300);
    repeat (40) @(negedge clk);
    check_val("crc_nresults", 64'(got_arg.size()), 1);
    check_val("crc_errs", got_errs[0], 16'h0002);
    check_val("crc_err",  got_err[0], 1);
    check_val("crc_code", got_code[0], 1);
`ifdef SD_CMD_QUEUE_RETRY_EN
    check_val("crc_launches", 64'(n_launch), 3);
`else
    check_val("crc_launches", 64'(n_launch), 1);
`endif

    // CRC error on first attempt only
    clear_mon(); m_err_first = 16'h0002; m_err_rest = 16'h0000;
    push(32'h0000_0DDD, 16'h1119, 1'b0, 1'b0);
    wait_done("crc1", 1, 300);
    repeat (40) @(negedge clk);
`ifdef SD_CMD_QUEUE_RETRY_EN
    check_val("crc1_launches", 64'(n_launch), 2);
    check_val("crc1_err", got_err[0], 0);
    check_val("crc1_errs", got_errs[0], 16'h0000);
`else
    check_val("crc1_launches", 64'(n_launch), 1);
    check_val("crc1_err", got_err[0], 1);
    check_val("crc1_errs", got_errs[0], 16'h0002);
`endif
    m_err_first = '0; m_err_rest = '0;

    // Reset during BUSY with 3 queued
    clear_mon(); m_busy = 30;
    for (int i = 0; i < 3; i++) push(32'h200 + 32'(i), 16'h0200, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !STATUS_REG[0]; i++) @(negedge clk);
    check_val("rst_busy_seen", STATUS_REG[0], 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst_level",  q_level, 0);
    check_val("midrst_newcmd", New_CMD, 0);
    check_val("midrst_ready",  req_ready, 1);
    check_val("midrst_dvalid", done_valid, 0);
    check_val("midrst_resp",   done_resp, 0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check_val("midrst_no_result", 64'(got_arg.size()), 0);

    // Push coinciding with the reporting pop
    clear_mon(); m_busy = 20;
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i), 16'h0300, 1'b0, 1'b0);
    for (int i = 0; i < 200 && !done_valid; i++) @(negedge clk);
    check_val("pp_in_report", done_valid, 1);
    check_val("pp_level_before", q_level, 3);
    req_valid = 1'b1; req_arg = 32'h303; req_cmd_set = 16'h0300;
    @(negedge clk);
    req_valid = 1'b0;
    check_val("pp_level_after", q_level, 3);
    wait_done("pp", 4, 400);
    for (int i = 0; i < 4; i++) check_val($sformatf("pp_order%0d", i), got_arg[i], 32'h300 + 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
